csr_trap_unit: RTL and testbench

//  Machine-mode CSR file and trap controller; parametrised successor of the single-hart CSR block.

---
 rtl/csr_pkg.sv | 51 +++++
 rtl/csr_trap_unit_counter64.sv | 31 +++
 rtl/csr_trap_unit.sv | 206 ++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, trap cause codes, interrupt bit positions and funct3 encodings.
package csr_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;

  localparam int unsigned IRQ_MSI   = 3;
  localparam int unsigned IRQ_MTI   = 7;
  localparam int unsigned IRQ_MEI   = 11;
  localparam int unsigned IRQ_FAST0 = 16;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [XLEN-1:0] MISA_VAL = 32'h4000_0100;

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit free-running event counter with inhibit and independent half-word write ports.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic        inc;
  logic [63:0] count_inc;

  assign inc       = en & ~inhibit;
  assign count_inc = count + 64'd1;

  // A write to one half replaces only that half; the other half still takes the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      if (wr_lo)    count[31:0]  <= wdata;
      else if (inc) count[31:0]  <= count_inc[31:0];
      if (wr_hi)    count[63:32] <= wdata;
      else if (inc) count[63:32] <= count_inc[63:32];
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR access, interrupt/exception entry,
// mret return, and mcycle/minstret counters.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned   NUM_FAST_IRQ = 16,
  parameter bit            VECTORED_EN  = 1'b1,
  parameter bit            COUNTER_EN   = 1'b1,
  parameter logic [31:0]   MTVEC_RESET  = 32'h0,
  parameter logic [31:0]   HART_ID      = 32'h0,
  localparam int unsigned  FAST_W       = (NUM_FAST_IRQ == 0) ? 1 : NUM_FAST_IRQ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_en,
  input  logic [11:0]       csr_addr,
  input  logic [2:0]        csr_funct3,
  input  logic [4:0]        csr_uimm,
  input  logic [XLEN-1:0]   csr_rs1_data,
  input  logic              inst_valid,
  input  logic              inst_retire,
  input  logic [XLEN-1:0]   pc,
  input  logic              illegal_inst,
  input  logic              ecall,
  input  logic              ebreak,
  input  logic              mret,
  input  logic              irq_sw,
  input  logic              irq_timer,
  input  logic              irq_ext,
  input  logic [FAST_W-1:0] irq_fast,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              csr_illegal
);

  localparam logic [31:0] FAST_MASK = (NUM_FAST_IRQ == 0) ? 32'h0 :
                                      (((32'h1 << NUM_FAST_IRQ) - 32'h1) << IRQ_FAST0);
  localparam logic [31:0] MIE_MASK  = (32'h1 << IRQ_MSI) | (32'h1 << IRQ_MTI) |
                                      (32'h1 << IRQ_MEI) | FAST_MASK;

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mcause_q, mtval_q;
  logic [31:2] mepc_q;
  logic        inhibit_cy, inhibit_ir;
  logic [63:0] mcycle, minstret;

  logic [31:0] mstatus_rd, mtvec_rd, mepc_rd, mip, irq_pend, csr_old, op, wdata;
  logic        csr_impl, wr_intent, csr_we, irq_take, exc_valid, trap, mret_take, vec_mode;
  logic [4:0]  irq_cause, exc_cause, trap_cause;
  csr_op_e     csr_op;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^pc[1:0];

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mtvec_rd   = {mtvec_q[31:2], VECTORED_EN ? mtvec_q[1:0] : 2'b00};
  assign mepc_rd    = {mepc_q, 2'b00};
  assign vec_mode   = (mtvec_rd[1:0] == 2'b01);

  // Live interrupt sources; mip is a view of the inputs, never latched.
  always_comb begin
    mip          = '0;
    mip[IRQ_MSI] = irq_sw;
    mip[IRQ_MTI] = irq_timer;
    mip[IRQ_MEI] = irq_ext;
    for (int unsigned i = 0; i < NUM_FAST_IRQ; i++) mip[IRQ_FAST0 + i] = irq_fast[i];
  end

  // Lowest fast index wins among fast lines; standard lines override in MEI > MSI > MTI order.
  always_comb begin
    irq_pend  = mip & mie_q;
    irq_cause = '0;
    for (int i = int'(NUM_FAST_IRQ) - 1; i >= 0; i--)
      if (irq_pend[int'(IRQ_FAST0) + i]) irq_cause = 5'(int'(IRQ_FAST0) + i);
    if (irq_pend[IRQ_MTI]) irq_cause = 5'(IRQ_MTI);
    if (irq_pend[IRQ_MSI]) irq_cause = 5'(IRQ_MSI);
    if (irq_pend[IRQ_MEI]) irq_cause = 5'(IRQ_MEI);
  end

  always_comb begin
    csr_old  = '0;
    csr_impl = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:       csr_old = mstatus_rd;
      CSR_MISA:          csr_old = MISA_VAL;
      CSR_MIE:           csr_old = mie_q;
      CSR_MTVEC:         csr_old = mtvec_rd;
      CSR_MCOUNTINHIBIT: csr_old = {29'b0, inhibit_ir, 1'b0, inhibit_cy};
      CSR_MSCRATCH:      csr_old = mscratch_q;
      CSR_MEPC:          csr_old = mepc_rd;
      CSR_MCAUSE:        csr_old = mcause_q;
      CSR_MTVAL:         csr_old = mtval_q;
      CSR_MIP:           csr_old = mip;
      CSR_MCYCLE:        csr_old = COUNTER_EN ? mcycle[31:0]    : 32'h0;
      CSR_MCYCLEH:       csr_old = COUNTER_EN ? mcycle[63:32]   : 32'h0;
      CSR_MINSTRET:      csr_old = COUNTER_EN ? minstret[31:0]  : 32'h0;
      CSR_MINSTRETH:     csr_old = COUNTER_EN ? minstret[63:32] : 32'h0;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_old = 32'h0;
      CSR_MHARTID:       csr_old = HART_ID;
      default:           csr_impl = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read and carries no write intent.
  always_comb begin
    csr_op    = csr_op_e'(csr_funct3[1:0]);
    op        = csr_funct3[2] ? {27'b0, csr_uimm} : csr_rs1_data;
    wdata     = op;
    wr_intent = 1'b0;
    case (csr_op)
      CSR_OP_RW: begin wdata = op;             wr_intent = csr_en;               end
      CSR_OP_RS: begin wdata = csr_old | op;   wr_intent = csr_en & (op != '0);  end
      CSR_OP_RC: begin wdata = csr_old & ~op;  wr_intent = csr_en & (op != '0);  end
      default:   begin wdata = op;             wr_intent = 1'b0;                 end
    endcase
  end

  always_comb begin
    csr_illegal = csr_en & (~csr_impl | (wr_intent & (csr_addr[11:10] == 2'b11)));
    irq_take    = inst_valid & mstatus_mie & (|irq_pend);
    exc_valid   = illegal_inst | csr_illegal | ebreak | ecall;
    if (illegal_inst | csr_illegal) exc_cause = CAUSE_ILLEGAL;
    else if (ebreak)                exc_cause = CAUSE_BREAKPOINT;
    else                            exc_cause = CAUSE_ECALL_M;
    trap        = irq_take | exc_valid;
    trap_cause  = irq_take ? irq_cause : exc_cause;
    mret_take   = mret & ~trap;
    csr_we      = wr_intent & ~trap & ~mret;
    redirect    = trap | mret_take;
    csr_rdata   = csr_en ? csr_old : 32'h0;
    if (mret_take)
      redirect_pc = mepc_rd;
    else if (irq_take & vec_mode)
      redirect_pc = {mtvec_rd[31:2], 2'b00} + {25'b0, irq_cause, 2'b00};
    else
      redirect_pc = {mtvec_rd[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      inhibit_cy   <= 1'b0;
      inhibit_ir   <= 1'b0;
    end else if (trap) begin
      mepc_q       <= pc[31:2];
      mcause_q     <= {irq_take, 26'b0, trap_cause};
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mtval_q      <= '0;
    end else if (mret_take) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= wdata[3];
          mstatus_mpie <= wdata[7];
        end
        CSR_MIE:      mie_q   <= wdata & MIE_MASK;
        CSR_MTVEC:    mtvec_q <= {wdata[31:2],
                                  (VECTORED_EN && wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
        CSR_MCOUNTINHIBIT: if (COUNTER_EN) begin
          inhibit_cy <= wdata[0];
          inhibit_ir <= wdata[2];
        end
        CSR_MSCRATCH: mscratch_q <= wdata;
        CSR_MEPC:     mepc_q     <= wdata[31:2];
        CSR_MCAUSE:   mcause_q   <= wdata;
        CSR_MTVAL:    mtval_q    <= wdata;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (COUNTER_EN),
    .inhibit (inhibit_cy),
    .wr_lo   (COUNTER_EN && csr_we && csr_addr == CSR_MCYCLE),
    .wr_hi   (COUNTER_EN && csr_we && csr_addr == CSR_MCYCLEH),
    .wdata   (wdata),
    .count   (mcycle)
  );

  // A trapped instruction is suppressed, so its retire pulse is not counted.
  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (COUNTER_EN && inst_retire && !trap),
    .inhibit (inhibit_ir),
    .wr_lo   (COUNTER_EN && csr_we && csr_addr == CSR_MINSTRET),
    .wr_hi   (COUNTER_EN && csr_we && csr_addr == CSR_MINSTRETH),
    .wdata   (wdata),
    .count   (minstret)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit: CSR ops, traps, mret and counters.
module tb_csr_trap_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_en, inst_valid, inst_retire, illegal_inst, ecall, ebreak, mret;
  logic        irq_sw, irq_timer, irq_ext;
  logic [15:0] irq_fast;
  logic [11:0] csr_addr;
  logic [2:0]  csr_funct3;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_rs1_data, pc;
  logic [31:0] csr_rdata, redirect_pc;
  logic        redirect, csr_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_trap_unit #(.NUM_FAST_IRQ(16)) dut (
    .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_addr(csr_addr),
    .csr_funct3(csr_funct3), .csr_uimm(csr_uimm), .csr_rs1_data(csr_rs1_data),
    .inst_valid(inst_valid), .inst_retire(inst_retire), .pc(pc),
    .illegal_inst(illegal_inst), .ecall(ecall), .ebreak(ebreak), .mret(mret),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_fast(irq_fast),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .csr_illegal(csr_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    csr_en = 0; csr_addr = '0; csr_funct3 = '0; csr_uimm = '0; csr_rs1_data = '0;
    inst_valid = 0; inst_retire = 0; illegal_inst = 0; ecall = 0; ebreak = 0; mret = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0; irq_fast = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] opnd);
    csr_en = 1; inst_valid = 1; csr_funct3 = f3; csr_addr = a;
    if (f3[2]) csr_uimm = opnd[4:0];
    else       csr_rs1_data = opnd;
    #1;
  endtask

  task automatic wr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] opnd);
    csr(f3, a, opnd);
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr(F3_CSRRS, a, 32'h0);
    check(tag, csr_rdata, exp);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    pc = 32'h0; rst_n = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_redirect", 32'(redirect), 32'h0);
    check("rst_rdata", csr_rdata, 32'h0);
    rst_n = 1; #1;
    rd_chk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    rd_chk("rst_mtvec", CSR_MTVEC, 32'h0);
    rd_chk("rst_mcause", CSR_MCAUSE, 32'h0);
    rd_chk("rst_mie", CSR_MIE, 32'h0);

    // CSRRW then a pure read via CSRRS x0
    csr(F3_CSRRW, CSR_MTVEC, 32'h100);
    check("mtvec_rw_old", csr_rdata, 32'h0);
    check("mtvec_rw_redirect", 32'(redirect), 32'h0);
    step();
    csr(F3_CSRRS, CSR_MTVEC, 32'h0);
    check("mtvec_rs0_rdata", csr_rdata, 32'h100);
    check("mtvec_rs0_illegal", 32'(csr_illegal), 32'h0);
    check("mtvec_rs0_redirect", 32'(redirect), 32'h0);
    step();
    rd_chk("mtvec_kept", CSR_MTVEC, 32'h100);

    // read-modify-write forms on mscratch
    wr(F3_CSRRW, CSR_MSCRATCH, 32'hF0F0);
    wr(F3_CSRRS, CSR_MSCRATCH, 32'h000F);
    rd_chk("mscratch_rs", CSR_MSCRATCH, 32'hF0FF);
    wr(F3_CSRRC, CSR_MSCRATCH, 32'h00F0);
    rd_chk("mscratch_rc", CSR_MSCRATCH, 32'hF00F);
    wr(F3_CSRRCI, CSR_MSCRATCH, 32'h0F);
    rd_chk("mscratch_rci", CSR_MSCRATCH, 32'hF000);

    // mtvec MODE legalisation
    wr(F3_CSRRW, CSR_MTVEC, 32'h203);
    rd_chk("mtvec_mode3", CSR_MTVEC, 32'h200);
    wr(F3_CSRRW, CSR_MTVEC, 32'h101);
    rd_chk("mtvec_mode1", CSR_MTVEC, 32'h101);

    // mie write mask, then timer interrupt into vectored mtvec
    wr(F3_CSRRW, CSR_MIE, 32'hFFFF_FFFF);
    rd_chk("mie_mask", CSR_MIE, 32'hFFFF_0888);
    wr(F3_CSRRW, CSR_MIE, 32'h80);
    wr(F3_CSRRSI, CSR_MSTATUS, 32'h8);
    rd_chk("mstatus_mie_set", CSR_MSTATUS, 32'h0000_1808);
    irq_timer = 1; inst_valid = 1; inst_retire = 1; pc = 32'h40; #1;
    check("mti_redirect", 32'(redirect), 32'h1);
    check("mti_pc", redirect_pc, 32'h11C);
    step();
    rd_chk("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
    rd_chk("mti_mepc", CSR_MEPC, 32'h40);
    rd_chk("mti_mstatus", CSR_MSTATUS, 32'h0000_1880);
    rd_chk("mti_minstret", CSR_MINSTRET, 32'h0);
    irq_timer = 1;
    csr(F3_CSRRS, CSR_MIP, 32'h0);
    check("mip_live", csr_rdata, 32'h80);
    check("mip_masked_by_mie0", 32'(redirect), 32'h0);
    step();

    // external interrupt beats a simultaneous illegal instruction
    wr(F3_CSRRS, CSR_MIE, 32'h800);
    wr(F3_CSRRSI, CSR_MSTATUS, 32'h8);
    irq_ext = 1; illegal_inst = 1; inst_valid = 1; pc = 32'h80; #1;
    check("mei_redirect", 32'(redirect), 32'h1);
    check("mei_pc", redirect_pc, 32'h12C);
    step();
    rd_chk("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
    rd_chk("mei_mepc", CSR_MEPC, 32'h80);

    // exceptions ignore vectored mode
    illegal_inst = 1; inst_valid = 1; pc = 32'h84; #1;
    check("ill_pc", redirect_pc, 32'h100);
    step();
    rd_chk("ill_mcause", CSR_MCAUSE, 32'h2);

    // write intent to read-only space traps; pure read does not
    wr(F3_CSRRW, CSR_MCAUSE, 32'h0);
    pc = 32'h88;
    csr(F3_CSRRW, CSR_MVENDORID, 32'h55);
    check("mvendorid_rw_illegal", 32'(csr_illegal), 32'h1);
    check("mvendorid_rw_redirect", 32'(redirect), 32'h1);
    check("mvendorid_rw_pc", redirect_pc, 32'h100);
    step();
    rd_chk("mvendorid_mcause", CSR_MCAUSE, 32'h2);
    rd_chk("mvendorid_mepc", CSR_MEPC, 32'h88);
    csr(F3_CSRRS, CSR_MVENDORID, 32'h0);
    check("mvendorid_rd_illegal", 32'(csr_illegal), 32'h0);
    check("mvendorid_rd_redirect", 32'(redirect), 32'h0);
    check("mvendorid_rd_data", csr_rdata, 32'h0);
    step();
    csr(F3_CSRRS, 12'h7C0, 32'h0);
    check("unimpl_illegal", 32'(csr_illegal), 32'h1);
    step();

    // ecall then mret
    wr(F3_CSRRSI, CSR_MSTATUS, 32'h8);
    ecall = 1; inst_valid = 1; pc = 32'h200; #1;
    check("ecall_redirect", 32'(redirect), 32'h1);
    check("ecall_pc", redirect_pc, 32'h100);
    step();
    rd_chk("ecall_mcause", CSR_MCAUSE, 32'd11);
    rd_chk("ecall_mepc", CSR_MEPC, 32'h200);
    rd_chk("ecall_mstatus", CSR_MSTATUS, 32'h0000_1880);
    mret = 1; inst_valid = 1; #1;
    check("mret_redirect", 32'(redirect), 32'h1);
    check("mret_pc", redirect_pc, 32'h200);
    step();
    rd_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
    wr(F3_CSRRCI, CSR_MSTATUS, 32'h8);

    // ebreak outranks ecall
    ebreak = 1; ecall = 1; inst_valid = 1; #1;
    step();
    rd_chk("ebreak_mcause", CSR_MCAUSE, 32'd3);

    // minstret counts a normal retirement
    inst_valid = 1; inst_retire = 1; #1;
    step();
    rd_chk("minstret_one", CSR_MINSTRET, 32'h1);

    // mcycle 64-bit wrap
    wr(F3_CSRRWI, CSR_MCOUNTINHIBIT, 32'h1);
    wr(F3_CSRRW, CSR_MCYCLEH, 32'hFFFF_FFFF);
    wr(F3_CSRRW, CSR_MCYCLE, 32'hFFFF_FFFF);
    rd_chk("mcycle_held_lo", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd_chk("mcycle_held_hi", CSR_MCYCLEH, 32'hFFFF_FFFF);
    wr(F3_CSRRWI, CSR_MCOUNTINHIBIT, 32'h0);
    rd_chk("mcycle_prewrap", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd_chk("mcycle_wrap_hi", CSR_MCYCLEH, 32'h0);
    rd_chk("mcycle_wrap_lo", CSR_MCYCLE, 32'h1);

    // write while running overrides the increment
    wr(F3_CSRRW, CSR_MCYCLE, 32'h5);
    rd_chk("mcycle_wr5", CSR_MCYCLE, 32'h5);
    rd_chk("mcycle_wr5_next", CSR_MCYCLE, 32'h6);
    wr(F3_CSRRW, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
    rd_chk("mcountinhibit_mask", CSR_MCOUNTINHIBIT, 32'h5);

    // reset asserted while a trap is being taken
    ecall = 1; inst_valid = 1; pc = 32'h300; #1;
    rst_n = 0;
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1; #1;
    rd_chk("rstmid_mcause", CSR_MCAUSE, 32'h0);
    rd_chk("rstmid_mepc", CSR_MEPC, 32'h0);
    rd_chk("rstmid_mscratch", CSR_MSCRATCH, 32'h0);
    rd_chk("rstmid_mstatus", CSR_MSTATUS, 32'h0000_1800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
